// File: rtl/axi_isolate_seq.sv
// Purpose : power-down sequencer driving the axi_isolate handshake, the domain clock gate and the power switch.
// Latency : Moore FSM, one cycle per transition; every output is decoded from registered state only.
// Backpr. : waits on isolated_i / pwr_ack_i; DRAIN gives up after TimeoutCycles, power handshakes never do.
//
// Ports: clk_i, rst_ni (async, active low); iso_req_i level request (1 = domain off);
//        isolate_o -> axi_isolate.isolate_i, isolated_i <- axi_isolate.isolated_o;
//        clk_en_o downstream clock enable; pwr_req_o / pwr_ack_i power switch 4-phase handshake;
//        state_o FSM encoding; timeout_err_o sticky timeout flag cleared by err_clr_i; busy_o in transit.
// Option : define AXI_ISOLATE_SEQ_PWR_EN to include the PWR_DN / PWR_UP power handshake states.
//          Without it GATE goes straight to OFF, OFF straight to UNGATE, and pwr_req_o is tied high.
module axi_isolate_seq #(
    parameter int unsigned TimeoutCycles   = 32'd1024,
    parameter int unsigned ClkSettleCycles = 32'd4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       iso_req_i,
    output logic       isolate_o,
    input  logic       isolated_i,
    output logic       clk_en_o,
    output logic       pwr_req_o,
    input  logic       pwr_ack_i,
    output logic [2:0] state_o,
    output logic       timeout_err_o,
    input  logic       err_clr_i,
    output logic       busy_o
);

    // A settle time of 0 still needs one cycle in GATE/UNGATE.
    localparam int unsigned SettleEff = (ClkSettleCycles < 32'd1) ? 32'd1 : ClkSettleCycles;
    localparam int unsigned CntMax    = (TimeoutCycles > SettleEff) ? TimeoutCycles : SettleEff;
    localparam int          CntW      = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] CntSat      = '1;
    localparam logic [CntW-1:0] CntOne      = CntW'(1);
    localparam logic [CntW-1:0] SettleLast  = CntW'(SettleEff - 32'd1);
    // Only meaningful when TimeoutCycles != 0; the timeout term is gated on that.
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 32'd1);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_GATE    = 3'd2,
        ST_PWR_DN  = 3'd3,
        ST_OFF     = 3'd4,
        ST_PWR_UP  = 3'd5,
        ST_UNGATE  = 3'd6,
        ST_RELEASE = 3'd7
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            wait_st;
    logic            timeout_hit;
    logic            pwr_req_tbl;

    // Next state, shared dwell counter and sticky error flag.
    always_comb begin
        state_d = state_q;
        wait_st = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                if (iso_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                wait_st = 1'b1;
                // A dropped request aborts even if isolation just completed.
                if (!iso_req_i)      state_d = ST_ACTIVE;
                else if (isolated_i) state_d = ST_GATE;
            end
            ST_GATE: begin
`ifdef AXI_ISOLATE_SEQ_PWR_EN
                if (cnt_q == SettleLast) state_d = ST_PWR_DN;
`else
                if (cnt_q == SettleLast) state_d = ST_OFF;
`endif
            end
`ifdef AXI_ISOLATE_SEQ_PWR_EN
            ST_PWR_DN: begin
                wait_st = 1'b1;
                if (!pwr_ack_i) state_d = ST_OFF;
            end
            ST_PWR_UP: begin
                wait_st = 1'b1;
                if (pwr_ack_i) state_d = ST_UNGATE;
            end
`endif
            ST_OFF: begin
`ifdef AXI_ISOLATE_SEQ_PWR_EN
                if (!iso_req_i) state_d = ST_PWR_UP;
`else
                if (!iso_req_i) state_d = ST_UNGATE;
`endif
            end
            ST_UNGATE: begin
                if (cnt_q == SettleLast) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                wait_st = 1'b1;
                if (!isolated_i) state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase

        // Timeout only when the wait would otherwise continue this cycle.
        timeout_hit = (TimeoutCycles != 32'd0) && wait_st && (state_d == state_q) &&
                      (cnt_q == TimeoutLast);
        // Only DRAIN may be abandoned; power handshakes keep waiting.
        if (timeout_hit && (state_q == ST_DRAIN)) state_d = ST_ACTIVE;

        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == CntSat) cnt_d = cnt_q;
        else                      cnt_d = cnt_q + CntOne;

        // Set wins over a simultaneous clear.
        if (timeout_hit)    err_d = 1'b1;
        else if (err_clr_i) err_d = 1'b0;
        else                err_d = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Moore output decode.
    always_comb begin
        isolate_o   = 1'b1;
        clk_en_o    = 1'b0;
        pwr_req_tbl = 1'b1;
        case (state_q)
            ST_ACTIVE, ST_RELEASE: begin
                isolate_o = 1'b0;
                clk_en_o  = 1'b1;
            end
            ST_DRAIN, ST_UNGATE: clk_en_o = 1'b1;
            ST_GATE, ST_PWR_UP:  clk_en_o = 1'b0;
            ST_PWR_DN, ST_OFF:   pwr_req_tbl = 1'b0;
            default: begin
                isolate_o = 1'b0;
                clk_en_o  = 1'b1;
            end
        endcase
    end

`ifdef AXI_ISOLATE_SEQ_PWR_EN
    assign pwr_req_o = pwr_req_tbl;
`else
    // No power switch: request stays on and the acknowledge is ignored.
    logic unused_pwr;
    assign unused_pwr = pwr_ack_i ^ pwr_req_tbl;
    assign pwr_req_o  = 1'b1;
`endif

    assign state_o       = state_q;
    assign timeout_err_o = err_q;
    assign busy_o        = !((state_q == ST_ACTIVE) || (state_q == ST_OFF));

endmodule

// File: tb/tb_axi_isolate_seq.sv
module tb_axi_isolate_seq;

    localparam int TO = 16;
    localparam int ST = 4;
`ifdef AXI_ISOLATE_SEQ_PWR_EN
    localparam bit PWR = 1'b1;
`else
    localparam bit PWR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       iso_req = 1'b0;
    logic       isolated = 1'b0;
    logic       pwr_ack = 1'b1;
    logic       err_clr = 1'b0;
    logic       isolate, clk_en, pwr_req, timeout_err, busy;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_isolate_seq #(.TimeoutCycles(TO), .ClkSettleCycles(ST)) dut (
        .clk_i(clk), .rst_ni(rst_n), .iso_req_i(iso_req), .isolate_o(isolate),
        .isolated_i(isolated), .clk_en_o(clk_en), .pwr_req_o(pwr_req),
        .pwr_ack_i(pwr_ack), .state_o(state), .timeout_err_o(timeout_err),
        .err_clr_i(err_clr), .busy_o(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int k;
        k = 0;
        while (state !== s && k < lim) begin
            cyc(1);
            k++;
        end
        chk(nm, {29'd0, state}, {29'd0, s});
    endtask

    // ---------------- reference model: state, cycles spent in it, error flag ----------------
    typedef struct packed {
        logic [2:0] st;
        int         dw;
        logic       err;
    } mstate_t;

    function automatic mstate_t mstep(mstate_t m, logic req, logic isod, logic ack, logic clr);
        mstate_t    r;
        logic [2:0] nx;
        logic       tmo;
        nx  = m.st;
        tmo = 1'b0;
        case (m.st)
            3'd0: if (req) nx = 3'd1;
            3'd1: if (!req) nx = 3'd0; else if (isod) nx = 3'd2;
            3'd2: if (m.dw >= ST) nx = PWR ? 3'd3 : 3'd4;
            3'd3: if (!ack) nx = 3'd4;
            3'd4: if (!req) nx = PWR ? 3'd5 : 3'd6;
            3'd5: if (ack) nx = 3'd6;
            3'd6: if (m.dw >= ST) nx = 3'd7;
            default: if (!isod) nx = 3'd0;
        endcase
        if ((m.st inside {3'd1, 3'd3, 3'd5, 3'd7}) && nx == m.st && m.dw == TO) begin
            tmo = 1'b1;
            if (m.st == 3'd1) nx = 3'd0;
        end
        r.err = tmo ? 1'b1 : (clr ? 1'b0 : m.err);
        r.dw  = (nx != m.st) ? 1 : m.dw + 1;
        r.st  = nx;
        return r;
    endfunction

    // {state, isolate, clk_en, pwr_req, timeout_err, busy}
    function automatic logic [7:0] mout(mstate_t m);
        logic i, c, p, b;
        i = !(m.st == 3'd0 || m.st == 3'd7);
        c = !(m.st inside {3'd2, 3'd3, 3'd4, 3'd5});
        p = PWR ? !(m.st == 3'd3 || m.st == 3'd4) : 1'b1;
        b = !(m.st == 3'd0 || m.st == 3'd4);
        return {m.st, i, c, p, m.err, b};
    endfunction

    mstate_t m;
    initial begin
        m = '{st: 3'd0, dw: 1, err: 1'b0};
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m = '{st: 3'd0, dw: 1, err: 1'b0};
            else        m = mstep(m, iso_req, isolated, pwr_ack, err_clr);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cycle", {24'd0, state, isolate, clk_en, pwr_req, timeout_err, busy}, {24'd0, mout(m)});
        end
    end

    // ---------------- axi_isolate / power switch responder ----------------
    logic       follow = 1'b1;
    logic       iso_force = 1'b0;
    logic       ack_force = 1'b1;
    logic [2:0] ih;
    logic [4:0] ah;
    initial begin
        ih = '0;
        ah = '1;
        forever begin
            @(negedge clk);
            ih = {ih[1:0], isolate};
            ah = {ah[3:0], pwr_req};
            if (follow) begin
                isolated = ih[2];
                pwr_ack  = ah[4];
            end else begin
                isolated = iso_force;
                pwr_ack  = ack_force;
            end
        end
    end

    // ---------------- sequence monitor ----------------
    logic [2:0] vis[$];
    logic [2:0] last_st;
    int         run, gate_dur, ungate_dur, err_hi, clk_lo, pwr_lo;
    task automatic clear_mon();
        vis.delete();
        last_st = state;
        run = 1; gate_dur = 0; ungate_dur = 0; err_hi = 0; clk_lo = 0; pwr_lo = 0;
    endtask
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (state != last_st) begin
                    if (last_st == 3'd2) gate_dur = run;
                    if (last_st == 3'd6) ungate_dur = run;
                    vis.push_back(state);
                    last_st = state;
                    run = 1;
                end else begin
                    run++;
                end
                if (timeout_err) err_hi++;
                if (!clk_en) clk_lo++;
                if (!pwr_req) pwr_lo++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int   n;
        int   exp_seq[$];
        logic [2:0] got;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_isolate", {31'd0, isolate}, 32'd0);
        chk("rst_clk_en", {31'd0, clk_en}, 32'd1);
        chk("rst_pwr_req", {31'd0, pwr_req}, 32'd1);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Full down/up cycle with responders in the loop.
        clear_mon();
        follow  = 1'b1;
        iso_req = 1'b1;
        wait_state(3'd4, 100, "full_reach_off");
        cyc(3);
        iso_req = 1'b0;
        wait_state(3'd0, 100, "full_back_active");
        cyc(2);
`ifdef AXI_ISOLATE_SEQ_PWR_EN
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 0};
        chk("full_pwr_dropped", {31'd0, pwr_lo > 0}, 32'd1);
`else
        exp_seq = '{1, 2, 4, 6, 7, 0};
        chk("full_pwr_const", pwr_lo, 32'd0);
`endif
        chk("full_visit_count", vis.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++) begin
            got = (i < vis.size()) ? vis[i] : 3'bxxx;
            chk($sformatf("full_visit_%0d", i), {29'd0, got}, exp_seq[i]);
        end
        chk("full_gate_len", gate_dur, 32'd4);
        chk("full_ungate_len", ungate_dur, 32'd4);
        chk("full_no_err", err_hi, 32'd0);

        // Drain abort.
        follow    = 1'b0;
        iso_force = 1'b0;
        ack_force = 1'b1;
        cyc(2);
        clear_mon();
        iso_req = 1'b1;
        cyc(10);
        chk("abort_in_drain", {29'd0, state}, 32'd1);
        iso_req = 1'b0;
        cyc(1);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_isolate", {31'd0, isolate}, 32'd0);
        chk("abort_clk_never_low", clk_lo, 32'd0);
        chk("abort_no_err", {31'd0, timeout_err}, 32'd0);

        // Drain timeout.
        iso_req = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (state == 3'd1) n++;
            else if (n > 0) break;
        end
        iso_req = 1'b0;
        chk("drain_to_cycles", n, 32'd16);
        chk("drain_to_state", {29'd0, state}, 32'd0);
        chk("drain_to_err", {31'd0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("err_clear", {31'd0, timeout_err}, 32'd0);

        // Timeout coincident with clear: flag must end up set.
        iso_req = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (state == 3'd1) begin
                n++;
                if (n == 16) err_clr = 1'b1;
            end else if (n > 0) begin
                break;
            end
        end
        err_clr = 1'b0;
        iso_req = 1'b0;
        chk("to_vs_clr_state", {29'd0, state}, 32'd0);
        chk("to_vs_clr_err", {31'd0, timeout_err}, 32'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;

`ifdef AXI_ISOLATE_SEQ_PWR_EN
        // Power-ack timeout: ack stuck high in PWR_DN.
        iso_force = 1'b1;
        ack_force = 1'b1;
        iso_req   = 1'b1;
        wait_state(3'd3, 50, "ack_reach_pwr_dn");
        cyc(15);
        chk("ack_err_early", {31'd0, timeout_err}, 32'd0);
        cyc(1);
        chk("ack_err_set", {31'd0, timeout_err}, 32'd1);
        chk("ack_still_pwr_dn", {29'd0, state}, 32'd3);
        ack_force = 1'b0;
        cyc(1);
        chk("ack_release_off", {29'd0, state}, 32'd4);
        iso_req   = 1'b0;
        ack_force = 1'b1;
        iso_force = 1'b0;
        wait_state(3'd0, 100, "ack_recover");
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
`endif

        // Reset mid-sequence while in OFF.
        follow  = 1'b1;
        cyc(4);
        iso_req = 1'b1;
        wait_state(3'd4, 100, "rst_reach_off");
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", {29'd0, state}, 32'd0);
        chk("midrst_isolate", {31'd0, isolate}, 32'd0);
        chk("midrst_clk_en", {31'd0, clk_en}, 32'd1);
        chk("midrst_pwr_req", {31'd0, pwr_req}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        iso_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);
        chk("midrst_idle", {29'd0, state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
